counter_game_ctrl: RTL and testbench

- Sequencer and arbiter in front of the multi-mode 4-bit up/down counter.
- Shares the counter's mode and init-load controls between two requesters (players) using a round-robin time-slot grant.
- Scores win events (counter enters all-ones) and lose events (counter enters zero) synchronously.
- Declares game over at TARGET and issues a timed clear pulse before a new game.

---
 rtl/counter_ctrl_pkg.sv | 27 ++
 rtl/counter_game_ctrl_if.sv | 39 +++
 rtl/counter_game_ctrl_rr_arbiter2.sv | 34 +++
 rtl/counter_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_counter_game_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and constants for the counter game controller.
//   state_t   : controller sequencing states
//   MODE_*    : counter control encodings driven on ctrl_mode
//   WHO_*     : game result encodings driven on who
// ----------------------------------------------------------------------------
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARB   = 3'd2,
        SLOT  = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_UP1 = 2'b00;
    localparam logic [1:0] MODE_UP2 = 2'b01;
    localparam logic [1:0] MODE_DN1 = 2'b10;
    localparam logic [1:0] MODE_DN2 = 2'b11;

    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_LOSER  = 2'b01;
    localparam logic [1:0] WHO_WINNER = 2'b10;

endpackage

// File: rtl/counter_game_ctrl_if.sv
// ----------------------------------------------------------------------------
// counter_game_ctrl_if
// Bundles the requester/counter side signals of counter_game_ctrl.
//   slave  : the controller (inputs start/req*/counter_value, drives the rest)
//   master : the environment (players and counter)
// ----------------------------------------------------------------------------
interface counter_game_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [1:0]           req;
    logic [3:0]           req_mode;
    logic [1:0]           req_init;
    logic [2*WIDTH-1:0]   req_init_value;
    logic [WIDTH-1:0]     counter_value;

    logic [1:0]           ctrl_mode;
    logic                 init_en;
    logic [WIDTH-1:0]     init_value;
    logic                 counter_clear;
    logic [1:0]           grant;
    logic [WIDTH-1:0]     win_count;
    logic [WIDTH-1:0]     lose_count;
    logic [1:0]           who;
    logic                 gameover;
    logic                 busy;

    modport slave (
        input  start, req, req_mode, req_init, req_init_value, counter_value,
        output ctrl_mode, init_en, init_value, counter_clear, grant,
               win_count, lose_count, who, gameover, busy
    );

    modport master (
        output start, req, req_mode, req_init, req_init_value, counter_value,
        input  ctrl_mode, init_en, init_value, counter_clear, grant,
               win_count, lose_count, who, gameover, busy
    );
endinterface

// File: rtl/counter_game_ctrl_rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin picker.
//   clk, rst : clock, async active-low reset
//   req      : request vector
//   take     : the current pick is being granted; advance the pointer
//   pick     : combinational one-hot choice (00 when no request)
// The pointer remembers the last granted requester and resets to 1 so that
// requester 0 wins the first contested pick.
// ----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] pick
);
    logic last;

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (take && (|req)) begin
            last <= pick[1];
        end
    end
endmodule

// File: rtl/counter_game_ctrl.sv
// ----------------------------------------------------------------------------
// counter_game_ctrl
// Sequencer/arbiter in front of a 4-bit multi-mode up/down counter. Two
// players share the counter in round-robin time slots; win (counter enters
// all-ones) and lose (counter enters zero) events are scored, and the game
// ends when either score reaches TARGET.
//   clk, rst : clock, async active-low reset
//   bus      : counter_game_ctrl_if.slave (start, req*, counter_value in;
//              ctrl_mode, init_en/value, counter_clear, grant, scores,
//              who, gameover, busy out)
//
// state | meaning
// IDLE  | after reset, waiting for start
// CLEAR | counter_clear pulse for CLEAR_CYCLES cycles, scores zeroed
// ARB   | no owner; pick next requester
// SLOT  | one requester owns the counter for up to SLOT_CYCLES cycles
// OVER  | score reached TARGET; outputs frozen until start
// ----------------------------------------------------------------------------
module counter_game_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int SLOT_CYCLES  = 4,
    parameter int TARGET       = 15,
    parameter int CLEAR_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    counter_game_ctrl_if.slave   bus
);
    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [CLR_W-1:0]  CLR_LOAD  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [WIDTH-1:0]  TGT       = WIDTH'(TARGET);
    localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};

    state_t             state;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [CLR_W-1:0]   clr_cnt;
    logic [WIDTH-1:0]   prev;

    logic [1:0]         ctrl_mode;
    logic               init_en;
    logic [WIDTH-1:0]   init_value;
    logic               counter_clear;
    logic [1:0]         grant;
    logic [WIDTH-1:0]   win_count;
    logic [WIDTH-1:0]   lose_count;
    logic [1:0]         who;
    logic               gameover;
    logic               busy;

    logic [1:0]         pick;
    logic               take;
    logic               playing;
    logic               end_now;
    logic               win_ev;
    logic               lose_ev;
    logic [1:0]         sel_mode;
    logic               sel_init;
    logic [WIDTH-1:0]   sel_value;

    always_comb begin
        playing   = (state == ARB) || (state == SLOT);
        end_now   = playing && ((win_count == TGT) || (lose_count == TGT));
        take      = (state == ARB) && !end_now;
        win_ev    = (bus.counter_value == ALL_ONES) && (prev != ALL_ONES);
        lose_ev   = (bus.counter_value == '0) && (prev != '0);
        sel_mode  = pick[1] ? bus.req_mode[3:2] : bus.req_mode[1:0];
        sel_init  = pick[1] ? bus.req_init[1] : bus.req_init[0];
        sel_value = pick[1] ? bus.req_init_value[2*WIDTH-1:WIDTH]
                            : bus.req_init_value[WIDTH-1:0];
    end

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (bus.req),
        .take (take),
        .pick (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            slot_cnt      <= '0;
            clr_cnt       <= '0;
            prev          <= WIDTH'(1);
            ctrl_mode     <= MODE_UP1;
            init_en       <= 1'b0;
            init_value    <= '0;
            counter_clear <= 1'b0;
            grant         <= 2'b00;
            win_count     <= '0;
            lose_count    <= '0;
            who           <= WHO_NONE;
            gameover      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            prev    <= bus.counter_value;
            // init load is a single-cycle pulse at the start of a slot
            init_en <= 1'b0;

            if (playing) begin
                if (win_ev && (win_count != TGT)) begin
                    win_count <= win_count + 1'b1;
                end
                if (lose_ev && (lose_count != TGT)) begin
                    lose_count <= lose_count + 1'b1;
                end
            end

            case (state)
                IDLE, OVER: begin
                    if (bus.start) begin
                        state         <= CLEAR;
                        counter_clear <= 1'b1;
                        clr_cnt       <= CLR_LOAD;
                        win_count     <= '0;
                        lose_count    <= '0;
                        who           <= WHO_NONE;
                        gameover      <= 1'b0;
                        ctrl_mode     <= MODE_UP1;
                        grant         <= 2'b00;
                        busy          <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        counter_clear <= 1'b0;
                        state         <= ARB;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                ARB, SLOT: begin
                    if (end_now) begin
                        // win is checked first so it wins a double-target tie
                        state    <= OVER;
                        gameover <= 1'b1;
                        who      <= (win_count == TGT) ? WHO_WINNER : WHO_LOSER;
                        grant    <= 2'b00;
                        busy     <= 1'b0;
                    end else if (state == ARB) begin
                        if (pick != 2'b00) begin
                            grant      <= pick;
                            ctrl_mode  <= sel_mode;
                            init_en    <= sel_init;
                            init_value <= sel_value;
                            slot_cnt   <= SLOT_LOAD;
                            state      <= SLOT;
                        end else begin
                            grant <= 2'b00;
                        end
                    end else begin
                        if ((slot_cnt == '0) || ((grant & bus.req) == 2'b00)) begin
                            grant <= 2'b00;
                            state <= ARB;
                        end else begin
                            slot_cnt <= slot_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ctrl_mode     = ctrl_mode;
    assign bus.init_en       = init_en;
    assign bus.init_value    = init_value;
    assign bus.counter_clear = counter_clear;
    assign bus.grant         = grant;
    assign bus.win_count     = win_count;
    assign bus.lose_count    = lose_count;
    assign bus.who           = who;
    assign bus.gameover      = gameover;
    assign bus.busy          = busy;
endmodule

// File: tb/tb_counter_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_counter_game_ctrl
// Directed bench for counter_game_ctrl: inputs are driven and outputs are
// sampled on the falling edge; expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_counter_game_ctrl;
    import counter_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    counter_game_ctrl_if #(.WIDTH(4)) bus ();

    counter_game_ctrl #(
        .WIDTH        (4),
        .SLOT_CYCLES  (4),
        .TARGET       (15),
        .CLEAR_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cc_hits;
        logic [1:0] exp_g;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.req = 2'b00;
        bus.req_mode = 4'b0000;
        bus.req_init = 2'b00;
        bus.req_init_value = 8'h00;
        bus.counter_value = 4'd0;
        repeat (2) @(negedge clk);

        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_clear", bus.counter_clear, 1'b0);
        chk("rst_gameover", bus.gameover, 1'b0);
        chk("rst_who", bus.who, WHO_NONE);

        rst = 1'b1;
        tick();
        chk("idle_no_start", bus.busy, 1'b0);

        // start pulse: clear for exactly two cycles, then ARB
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cc_hits = (bus.counter_clear === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.counter_clear === 1'b1) cc_hits++;
        end
        chk("clear_len", cc_hits, 2);
        chk("arb_busy", bus.busy, 1'b1);
        chk("arb_grant", bus.grant, 2'b00);
        chk("arb_win0", bus.win_count, 4'd0);
        chk("arb_lose0", bus.lose_count, 4'd0);

        // both request: 4-cycle slots separated by one idle cycle, alternating
        bus.req_mode = {MODE_DN1, MODE_UP1};
        bus.req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_g = ((i % 5) == 4) ? 2'b00 : (((i / 5) % 2) == 1 ? 2'b10 : 2'b01);
            chk("rr_grant", bus.grant, exp_g);
            if (exp_g == 2'b01) chk("rr_mode0", bus.ctrl_mode, MODE_UP1);
            if (exp_g == 2'b10) chk("rr_mode1", bus.ctrl_mode, MODE_DN1);
        end
        bus.req = 2'b00;
        tick();
        chk("rr_idle", bus.grant, 2'b00);

        // init load only in the first slot cycle
        bus.req_mode = {MODE_DN2, MODE_UP2};
        bus.req_init = 2'b01;
        bus.req_init_value = 8'h0E;
        bus.req = 2'b01;
        tick();
        chk("init_grant", bus.grant, 2'b01);
        chk("init_en1", bus.init_en, 1'b1);
        chk("init_val", bus.init_value, 4'hE);
        chk("init_mode", bus.ctrl_mode, MODE_UP2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("init_en0", bus.init_en, 1'b0);
            chk("init_mode_hold", bus.ctrl_mode, MODE_UP2);
            chk("init_grant_hold", bus.grant, 2'b01);
        end
        bus.req = 2'b00;
        bus.req_init = 2'b00;
        tick();
        chk("init_slot_end", bus.grant, 2'b00);

        // requester drop ends the slot early
        bus.req = 2'b01;
        tick();
        chk("drop_grant", bus.grant, 2'b01);
        bus.req = 2'b00;
        tick();
        chk("drop_release", bus.grant, 2'b00);

        // a held zero scores one lose
        bus.counter_value = 4'd5;
        tick();
        bus.counter_value = 4'd0;
        repeat (10) tick();
        chk("lose_once", bus.lose_count, 4'd1);
        chk("lose_nowin", bus.win_count, 4'd0);

        // win scoring up to target then game over
        for (int k = 1; k <= 15; k++) begin
            bus.counter_value = 4'd14;
            tick();
            bus.counter_value = 4'd15;
            tick();
            chk("win_cnt", bus.win_count, 32'(k));
        end
        chk("win_not_over", bus.gameover, 1'b0);
        bus.req = 2'b11;
        bus.counter_value = 4'd14;
        tick();
        chk("over_flag", bus.gameover, 1'b1);
        chk("over_who", bus.who, WHO_WINNER);
        chk("over_grant", bus.grant, 2'b00);
        chk("over_busy", bus.busy, 1'b0);
        bus.counter_value = 4'd15;
        tick();
        chk("over_frozen_win", bus.win_count, 4'd15);
        chk("over_frozen_lose", bus.lose_count, 4'd1);
        chk("over_req_ignored", bus.grant, 2'b00);
        bus.req = 2'b00;

        // restart from OVER clears scores
        bus.counter_value = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_clear", bus.counter_clear, 1'b1);
        chk("restart_win", bus.win_count, 4'd0);
        chk("restart_lose", bus.lose_count, 4'd0);
        chk("restart_gameover", bus.gameover, 1'b0);
        chk("restart_who", bus.who, WHO_NONE);
        repeat (2) tick();
        chk("restart_arb", bus.counter_clear, 1'b0);

        // reset mid-slot with an init load in flight
        bus.req_mode = {MODE_DN2, MODE_DN1};
        bus.req_init = 2'b01;
        bus.req_init_value = 8'h0E;
        bus.req = 2'b01;
        tick();
        chk("pre_rst_init", bus.init_en, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", bus.grant, 2'b00);
        chk("mid_rst_init", bus.init_en, 1'b0);
        chk("mid_rst_mode", bus.ctrl_mode, 2'b00);
        chk("mid_rst_clear", bus.counter_clear, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", bus.busy, 1'b0);
        chk("post_rst_grant", bus.grant, 2'b00);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("post_rst_start", bus.counter_clear, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
